// File: rtl/dual_port_ram_arbiter.sv
// Round-robin arbiter sharing one port of a 16x8 bidirectional RAM between two
// req/ack requesters. A single FSM sequences cs/wr_en/out_en/add_in and is the
// only owner of the data bus on this side, which it drives only in WR.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | port free; arbitrate between req_0 / req_1 (round robin)
// WR    | write cycle: cs, wr_en, address and write data on the bus
// RD    | first read cycle: cs, out_en, bus released for the RAM
// CAP   | second read cycle: RAM data captured into rdata_<grant>
// DONE  | ack_<grant> pulse, all strobes low, bus released
module dual_port_ram_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_0,
    input  logic              we_0,
    input  logic [ADDR_W-1:0] addr_0,
    input  logic [DATA_W-1:0] wdata_0,
    output logic              ack_0,
    output logic [DATA_W-1:0] rdata_0,
    input  logic              req_1,
    input  logic              we_1,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [DATA_W-1:0] wdata_1,
    output logic              ack_1,
    output logic [DATA_W-1:0] rdata_1,
    output logic              cs,
    output logic              wr_en,
    output logic              out_en,
    output logic [ADDR_W-1:0] add_in,
    inout  wire  [DATA_W-1:0] data_io,
    output logic              busy,
    output logic              grant
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD   = 3'd2,
        CAP  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t            state;
    logic              last_grant;
    logic              drive;
    logic [DATA_W-1:0] wdata_q;

    logic              pick_1;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Requester chosen if arbitration happens this cycle: a lone request wins,
    // otherwise the side that was not served last.
    always_comb begin
        pick_1    = req_1 && (!req_0 || !last_grant);
        sel_we    = pick_1 ? we_1    : we_0;
        sel_addr  = pick_1 ? addr_1  : addr_0;
        sel_wdata = pick_1 ? wdata_1 : wdata_0;
    end

    // The bus is driven only while the registered WR drive flag is set.
    assign data_io = drive ? wdata_q : {DATA_W{1'bz}};

    // Transaction sequencer with all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cs         <= 1'b0;
            wr_en      <= 1'b0;
            out_en     <= 1'b0;
            add_in     <= '0;
            drive      <= 1'b0;
            wdata_q    <= '0;
            ack_0      <= 1'b0;
            ack_1      <= 1'b0;
            rdata_0    <= '0;
            rdata_1    <= '0;
            busy       <= 1'b0;
            grant      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            ack_0 <= 1'b0;
            ack_1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_0 || req_1) begin
                        grant      <= pick_1;
                        last_grant <= pick_1;
                        add_in     <= sel_addr;
                        wdata_q    <= sel_wdata;
                        busy       <= 1'b1;
                        cs         <= 1'b1;
                        if (sel_we) begin
                            state <= WR;
                            wr_en <= 1'b1;
                            drive <= 1'b1;
                        end else begin
                            state  <= RD;
                            out_en <= 1'b1;
                        end
                    end
                end
                WR: begin
                    state <= DONE;
                    cs    <= 1'b0;
                    wr_en <= 1'b0;
                    drive <= 1'b0;
                    if (grant) ack_1 <= 1'b1;
                    else       ack_0 <= 1'b1;
                end
                RD: begin
                    state <= CAP;
                end
                CAP: begin
                    state  <= DONE;
                    cs     <= 1'b0;
                    out_en <= 1'b0;
                    if (grant) begin
                        rdata_1 <= data_io;
                        ack_1   <= 1'b1;
                    end else begin
                        rdata_0 <= data_io;
                        ack_0   <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    cs     <= 1'b0;
                    wr_en  <= 1'b0;
                    out_en <= 1'b0;
                    drive  <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dual_port_ram_arbiter.sv
// Directed bench for dual_port_ram_arbiter with a behavioural 16x8 RAM.
// Whenever cs is low the bench itself drives 8'h00 onto the shared bus, so
// any stray drive from the arbiter shows up as a non-zero bus value.
module tb_dual_port_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_0, we_0, req_1, we_1;
    logic [3:0] addr_0, addr_1;
    logic [7:0] wdata_0, wdata_1;
    logic       ack_0, ack_1;
    logic [7:0] rdata_0, rdata_1;
    logic       cs, wr_en, out_en, busy, grant;
    logic [3:0] add_in;
    wire  [7:0] data_io;

    logic [7:0] mem [16];
    int tests_run = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dual_port_ram_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .wdata_0(wdata_0),
        .ack_0(ack_0), .rdata_0(rdata_0),
        .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1),
        .ack_1(ack_1), .rdata_1(rdata_1),
        .cs(cs), .wr_en(wr_en), .out_en(out_en), .add_in(add_in),
        .data_io(data_io), .busy(busy), .grant(grant)
    );

    // RAM model: drives during reads, otherwise the bench parks the bus at 00.
    assign data_io = (cs && out_en && !wr_en) ? mem[add_in] :
                     (!cs ? 8'h00 : 8'hzz);

    always @(posedge clk) begin
        if (cs && wr_en) mem[add_in] <= data_io;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst_n = 1'b0;
        req_0 = 1'b1; we_0 = 1'b1; addr_0 = 4'h1; wdata_0 = 8'hFF;
        req_1 = 1'b1; we_1 = 1'b1; addr_1 = 4'h2; wdata_1 = 8'hEE;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({cs, wr_en, out_en} !== 3'b000) begin
            fails++; $display("FAIL reset_strobes: got %b want 000", {cs, wr_en, out_en});
        end
        tests_run++;
        if ({ack_0, ack_1, busy, grant} !== 4'b0000) begin
            fails++; $display("FAIL reset_ack_busy: got %b want 0000", {ack_0, ack_1, busy, grant});
        end
        tests_run++;
        if (data_io !== 8'h00 || rdata_0 !== 8'h00 || rdata_1 !== 8'h00 || add_in !== 4'h0) begin
            fails++; $display("FAIL reset_bus_data: bus %h rd0 %h rd1 %h add %h want all 0",
                              data_io, rdata_0, rdata_1, add_in);
        end
        req_0 = 1'b0; req_1 = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_write();
        req_0 = 1'b1; we_0 = 1'b1; addr_0 = 4'h3; wdata_0 = 8'hA5;
        @(negedge clk);
        tests_run++;
        if ({cs, wr_en, out_en, busy, grant} !== 5'b11010 || add_in !== 4'h3 || data_io !== 8'hA5) begin
            fails++; $display("FAIL write_wr_cycle: cs/we/oe/busy/gnt %b add %h bus %h want 11010 3 a5",
                              {cs, wr_en, out_en, busy, grant}, add_in, data_io);
        end
        tests_run++;
        if (ack_0 !== 1'b0) begin
            fails++; $display("FAIL write_early_ack: got %b want 0", ack_0);
        end
        @(negedge clk);
        tests_run++;
        if ({ack_0, ack_1, cs, wr_en} !== 4'b1000 || data_io !== 8'h00) begin
            fails++; $display("FAIL write_done: ack0/ack1/cs/we %b bus %h want 1000 00",
                              {ack_0, ack_1, cs, wr_en}, data_io);
        end
        req_0 = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({ack_0, busy} !== 2'b00 || mem[3] !== 8'hA5) begin
            fails++; $display("FAIL write_result: ack0/busy %b mem[3] %h want 00 a5", {ack_0, busy}, mem[3]);
        end
    endtask

    task automatic test_read_back();
        req_0 = 1'b1; we_0 = 1'b0; addr_0 = 4'h3; wdata_0 = 8'h00;
        @(negedge clk);
        tests_run++;
        if ({cs, wr_en, out_en} !== 3'b101 || add_in !== 4'h3 || data_io !== 8'hA5) begin
            fails++; $display("FAIL read_rd_cycle: cs/we/oe %b add %h bus %h want 101 3 a5",
                              {cs, wr_en, out_en}, add_in, data_io);
        end
        @(negedge clk);
        tests_run++;
        if ({cs, wr_en, out_en, ack_0} !== 4'b1010 || data_io !== 8'hA5) begin
            fails++; $display("FAIL read_cap_cycle: cs/we/oe/ack0 %b bus %h want 1010 a5",
                              {cs, wr_en, out_en, ack_0}, data_io);
        end
        @(negedge clk);
        tests_run++;
        if ({ack_0, out_en, cs} !== 3'b100 || rdata_0 !== 8'hA5) begin
            fails++; $display("FAIL read_ack: ack0/oe/cs %b rdata_0 %h want 100 a5", {ack_0, out_en, cs}, rdata_0);
        end
        req_0 = 1'b0;
        @(negedge clk);
        tests_run++;
        if (rdata_0 !== 8'hA5 || ack_0 !== 1'b0) begin
            fails++; $display("FAIL read_hold: rdata_0 %h ack0 %b want a5 0", rdata_0, ack_0);
        end
    endtask

    task automatic test_contention();
        int n_acks;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req_0 = 1'b1; we_0 = 1'b1; addr_0 = 4'h5; wdata_0 = 8'h11;
        req_1 = 1'b1; we_1 = 1'b1; addr_1 = 4'h6; wdata_1 = 8'h22;
        n_acks = 0;
        for (int cyc = 0; cyc < 60 && n_acks < 8; cyc++) begin
            @(negedge clk);
            tests_run++;
            if (ack_0 && ack_1) begin
                fails++; $display("FAIL contention_overlap: both acks high at cycle %0d", cyc);
            end
            if (ack_0 || ack_1) begin
                tests_run++;
                if ({ack_1, ack_0} !== ((n_acks % 2 == 1) ? 2'b10 : 2'b01)) begin
                    fails++; $display("FAIL contention_order: ack %0d got {ack1,ack0}=%b want %b",
                                      n_acks, {ack_1, ack_0}, (n_acks % 2 == 1) ? 2'b10 : 2'b01);
                end
                n_acks++;
                if (n_acks == 8) begin
                    req_0 = 1'b0; req_1 = 1'b0;
                end
            end
        end
        tests_run++;
        if (n_acks != 8) begin
            fails++; $display("FAIL contention_count: got %0d acks want 8", n_acks);
            req_0 = 1'b0; req_1 = 1'b0;
        end
        @(negedge clk);
        tests_run++;
        if (mem[5] !== 8'h11 || mem[6] !== 8'h22 || busy !== 1'b0) begin
            fails++; $display("FAIL contention_data: mem5 %h mem6 %h busy %b want 11 22 0", mem[5], mem[6], busy);
        end
    endtask

    task automatic test_turnaround();
        req_1 = 1'b1; we_1 = 1'b0; addr_1 = 4'h6;
        @(negedge clk);
        tests_run++;
        if ({out_en, grant} !== 2'b11 || data_io !== 8'h22) begin
            fails++; $display("FAIL turn_rd: oe/grant %b bus %h want 11 22", {out_en, grant}, data_io);
        end
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if ({ack_1, out_en, cs} !== 3'b100 || rdata_1 !== 8'h22 || data_io !== 8'h00) begin
            fails++; $display("FAIL turn_done: ack1/oe/cs %b rdata_1 %h bus %h want 100 22 00",
                              {ack_1, out_en, cs}, rdata_1, data_io);
        end
        req_1 = 1'b0;
        req_0 = 1'b1; we_0 = 1'b1; addr_0 = 4'h7; wdata_0 = 8'h3C;
        @(negedge clk);
        tests_run++;
        if ({cs, wr_en, busy} !== 3'b000 || data_io !== 8'h00) begin
            fails++; $display("FAIL turn_idle_gap: cs/we/busy %b bus %h want 000 00", {cs, wr_en, busy}, data_io);
        end
        @(negedge clk);
        tests_run++;
        if ({cs, wr_en, out_en, grant} !== 4'b1100 || data_io !== 8'h3C) begin
            fails++; $display("FAIL turn_wr: cs/we/oe/grant %b bus %h want 1100 3c",
                              {cs, wr_en, out_en, grant}, data_io);
        end
        @(negedge clk);
        req_0 = 1'b0;
        @(negedge clk);
        tests_run++;
        if (mem[7] !== 8'h3C) begin
            fails++; $display("FAIL turn_mem: mem7 %h want 3c", mem[7]);
        end
    endtask

    task automatic test_reset_mid_read();
        req_1 = 1'b1; we_1 = 1'b0; addr_1 = 4'h3;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if ({cs, out_en, busy} !== 3'b111) begin
            fails++; $display("FAIL midrst_cap: cs/oe/busy %b want 111", {cs, out_en, busy});
        end
        rst_n = 1'b0;
        @(negedge clk);
        req_1 = 1'b0;
        tests_run++;
        if ({ack_0, ack_1, cs, out_en, busy} !== 5'b00000 || rdata_1 !== 8'h00) begin
            fails++; $display("FAIL midrst_reset: ack0/ack1/cs/oe/busy %b rdata_1 %h want 00000 00",
                              {ack_0, ack_1, cs, out_en, busy}, rdata_1);
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            tests_run++;
            if ({ack_0, ack_1, busy, cs} !== 4'b0000 || rdata_1 !== 8'h00) begin
                fails++; $display("FAIL midrst_after: ack0/ack1/busy/cs %b rdata_1 %h want 0000 00",
                                  {ack_0, ack_1, busy, cs}, rdata_1);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        test_reset();
        test_single_write();
        test_read_back();
        test_contention();
        test_turnaround();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
